// File: rtl/wash_seq.sv
// ============================================================================
// Module   : wash_seq
// Purpose  : Wash-cycle scheduler. On a start pulse it latches mode, weight
//            and balance. It checks the weight limit and the price, deducts
//            the price, then runs FILL -> WASH -> RINSE -> SPIN. Each phase
//            has a seconds countdown driven by a TICK_CYC prescaler. The
//            block supports pause/resume and a lid-open interlock.
// Ports    : clk, rst (async, active-low)
//            start, mode[1:0], weight[4:0], bal_in[11:0] - program request
//            pause_pos, ack_pos, lid_open               - operator controls
//            busy, phase[2:0], remain_s[7:0]            - status/display
//            bal_out[11:0]                              - balance after cost
//            valve_in, valve_out, motor                 - actuators
//            done, err, paused, buzz                    - indicators
// Options  : BUZZ_EN - when defined, buzz pulses for 2*TICK_CYC cycles on
//            entry to DONE or ERR. When undefined, buzz is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wash_seq #(
   parameter int TICK_CYC = 100000000,
   parameter int PRICE0   = 2,
   parameter int PRICE1   = 5,
   parameter int PRICE2   = 8,
   parameter int PRICE3   = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [4:0]         weight,
   input  logic signed [11:0] bal_in,
   input  logic               pause_pos,
   input  logic               ack_pos,
   input  logic               lid_open,
   output logic               busy,
   output logic [2:0]         phase,
   output logic [7:0]         remain_s,
   output logic signed [11:0] bal_out,
   output logic               valve_in,
   output logic               valve_out,
   output logic               motor,
   output logic               done,
   output logic               err,
   output logic               paused,
   output logic               buzz
);

   localparam logic [3:0] c_IDLE  = 4'd0;
   localparam logic [3:0] c_CHECK = 4'd1;
   localparam logic [3:0] c_FILL  = 4'd2;
   localparam logic [3:0] c_WASH  = 4'd3;
   localparam logic [3:0] c_RINSE = 4'd4;
   localparam logic [3:0] c_SPIN  = 4'd5;
   localparam logic [3:0] c_PAUSE = 4'd6;
   localparam logic [3:0] c_DONE  = 4'd7;
   localparam logic [3:0] c_ERR   = 4'd8;

   localparam int            c_PW        = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_CYC - 1);

   logic [3:0]         r_state;
   logic [3:0]         w_state_nxt;
   logic [3:0]         r_ret;
   logic [1:0]         r_mode;
   logic [4:0]         r_weight;
   logic signed [11:0] r_bal;
   logic signed [11:0] r_bal_out;
   logic [7:0]         r_remain;
   logic [c_PW-1:0]    r_presc;

   logic               w_fail;
   logic signed [11:0] w_cost;
   logic [4:0]         w_limit;
   logic               w_wrap;
   logic               w_end;
   logic               w_last;
   logic               w_preq;
   logic               w_adv;
   logic [3:0]         w_nxt_phase;

   // Phase duration in seconds. States without a duration (DONE etc.) give 0.
   function automatic logic [7:0] f_dur(input logic [3:0] ph,
                                        input logic [1:0] m,
                                        input logic [4:0] w);
      logic [7:0] w8;
      w8    = {3'b000, w};
      f_dur = 8'd0;
      case (ph)
         c_FILL:  case (m)
                     2'd1:    f_dur = 8'd5;
                     2'd2:    f_dur = 8'd8;
                     2'd3:    f_dur = 8'd10;
                     default: f_dur = 8'd0;
                  endcase
         c_WASH:  case (m)
                     2'd1:    f_dur = 8'd20 + w8;
                     2'd2:    f_dur = 8'd30 + w8;
                     2'd3:    f_dur = 8'd40 + (w8 << 1);
                     default: f_dur = 8'd0;
                  endcase
         c_RINSE: case (m)
                     2'd1:    f_dur = 8'd10;
                     2'd2:    f_dur = 8'd15;
                     2'd3:    f_dur = 8'd20;
                     default: f_dur = 8'd0;
                  endcase
         c_SPIN:  case (m)
                     2'd0:    f_dur = 8'd10 + w8;
                     2'd1:    f_dur = 8'd10;
                     2'd2:    f_dur = 8'd15;
                     default: f_dur = 8'd20;
                  endcase
         default: f_dur = 8'd0;
      endcase
   endfunction

   // ---------------------------------------------------------------- checks
   always_comb begin
      w_cost  = 12'(PRICE0);
      w_limit = 5'd20;
      case (r_mode)
         2'd0:    begin w_cost = 12'(PRICE0); w_limit = 5'd20; end
         2'd1:    begin w_cost = 12'(PRICE1); w_limit = 5'd5;  end
         2'd2:    begin w_cost = 12'(PRICE2); w_limit = 5'd10; end
         default: begin w_cost = 12'(PRICE3); w_limit = 5'd20; end
      endcase
   end

   assign w_fail = (r_weight > w_limit) || (r_bal < w_cost);

   always_comb begin
      case (r_state)
         c_FILL:  w_nxt_phase = c_WASH;
         c_WASH:  w_nxt_phase = c_RINSE;
         c_RINSE: w_nxt_phase = c_SPIN;
         default: w_nxt_phase = c_DONE;
      endcase
   end

   // A phase ends in the cycle where remain_s is already 0. This rule also
   // covers zero-length phases, which are skipped after one cycle. A pause
   // request that coincides with the final tick (remain 1 -> 0) or with
   // the end cycle takes the transition first, so the next phase is entered
   // already paused.
   assign w_wrap = (r_presc == c_PRESC_MAX);
   assign w_end  = (r_remain == 8'd0);
   assign w_last = w_wrap && (r_remain == 8'd1);
   assign w_preq = pause_pos | lid_open;
   assign w_adv  = w_end | (w_last & w_preq);

   // ------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= c_IDLE;
      else      r_state <= w_state_nxt;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (start) w_state_nxt = c_CHECK;
         c_CHECK: w_state_nxt = w_fail ? c_ERR : c_FILL;
         c_FILL, c_WASH, c_RINSE, c_SPIN: begin
            if (w_adv)
               w_state_nxt = (w_preq && (w_nxt_phase != c_DONE)) ? c_PAUSE
                                                                 : w_nxt_phase;
            else if (w_preq)
               w_state_nxt = c_PAUSE;
         end
         c_PAUSE: if (pause_pos && !lid_open) w_state_nxt = r_ret;
         c_DONE, c_ERR: if (ack_pos) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ret     <= c_IDLE;
         r_mode    <= 2'd0;
         r_weight  <= 5'd0;
         r_bal     <= 12'sd0;
         r_bal_out <= 12'sd0;
         r_remain  <= 8'd0;
         r_presc   <= '0;
      end else begin
         case (r_state)
            c_IDLE: if (start) begin
               r_mode   <= mode;
               r_weight <= weight;
               r_bal    <= bal_in;
            end
            c_CHECK: if (!w_fail) begin
               r_bal_out <= r_bal - w_cost;
               r_remain  <= f_dur(c_FILL, r_mode, r_weight);
               r_presc   <= '0;
            end
            c_FILL, c_WASH, c_RINSE, c_SPIN: begin
               if (w_adv) begin
                  r_remain <= f_dur(w_nxt_phase, r_mode, r_weight);
                  r_presc  <= '0;
                  r_ret    <= w_nxt_phase;
               end else if (w_preq) begin
                  // Counters freeze from the request cycle onward.
                  r_ret <= r_state;
               end else if (w_wrap) begin
                  r_presc  <= '0;
                  r_remain <= r_remain - 8'd1;
               end else begin
                  r_presc <= r_presc + 1'b1;
               end
            end
            c_DONE, c_ERR: if (ack_pos) r_remain <= 8'd0;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------- outputs
   always_comb begin
      busy      = 1'b1;
      phase     = 3'b000;
      valve_in  = 1'b0;
      valve_out = 1'b0;
      motor     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      paused    = 1'b0;
      case (r_state)
         c_IDLE:  busy = 1'b0;
         c_FILL:  begin phase = 3'b001; valve_in = 1'b1; end
         c_WASH:  begin phase = 3'b001; motor = 1'b1; end
         c_RINSE: begin phase = 3'b010; valve_in = 1'b1; motor = 1'b1; end
         c_SPIN:  begin phase = 3'b100; valve_out = 1'b1; motor = 1'b1; end
         c_PAUSE: paused = 1'b1;
         c_DONE:  begin busy = 1'b0; done = 1'b1; end
         c_ERR:   begin busy = 1'b0; err = 1'b1; end
         default: ;
      endcase
   end

   assign remain_s = r_remain;
   assign bal_out  = r_bal_out;

`ifdef BUZZ_EN
   localparam int c_BW = $clog2(2 * TICK_CYC + 1);
   logic [c_BW-1:0] r_buzz_cnt;
   logic            w_term_entry;

   assign w_term_entry = ((w_state_nxt == c_DONE) || (w_state_nxt == c_ERR)) &&
                         !((r_state == c_DONE) || (r_state == c_ERR));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              r_buzz_cnt <= '0;
      else if (w_term_entry) r_buzz_cnt <= c_BW'(2 * TICK_CYC);
      else if (r_buzz_cnt != '0) r_buzz_cnt <= r_buzz_cnt - 1'b1;
   end

   assign buzz = (r_buzz_cnt != '0);
`else
   assign buzz = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wash_seq.sv
// ============================================================================
// Module   : tb_wash_seq
// Purpose  : Self-checking bench for wash_seq with TICK_CYC=4. Fixed program
//            vectors and random programs are checked against a
//            timeline model built from the duration/price table. Hand-written
//            sequences cover pause, lid, end-of-phase pause and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wash_seq;

   localparam int TICK = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               start, pause_pos, ack_pos, lid_open;
   logic [1:0]         mode;
   logic [4:0]         weight;
   logic signed [11:0] bal_in;
   logic               busy, valve_in, valve_out, motor, done, err, paused, buzz;
   logic [2:0]         phase;
   logic [7:0]         remain_s;
   logic signed [11:0] bal_out;

   wash_seq #(.TICK_CYC(TICK)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .weight(weight),
      .bal_in(bal_in), .pause_pos(pause_pos), .ack_pos(ack_pos),
      .lid_open(lid_open), .busy(busy), .phase(phase), .remain_s(remain_s),
      .bal_out(bal_out), .valve_in(valve_in), .valve_out(valve_out),
      .motor(motor), .done(done), .err(err), .paused(paused), .buzz(buzz)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   wire [6:0]  w_lights = {phase, valve_in, valve_out, motor, busy};
   wire [30:0] w_all    = {busy, phase, remain_s, bal_out, valve_in, valve_out,
                           motor, done, err, paused, buzz};

   typedef struct {
      int m;
      int w;
      int bal;
      bit e_err;
      int e_bal;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---- reference model: program table ----
   function automatic int price_of(input int m);
      case (m)
         0: return 2;
         1: return 5;
         2: return 8;
         default: return 12;
      endcase
   endfunction

   function automatic int limit_of(input int m);
      case (m)
         1: return 5;
         2: return 10;
         default: return 20;
      endcase
   endfunction

   // p: 0 FILL, 1 WASH, 2 RINSE, 3 SPIN
   function automatic int dur(input int m, input int w, input int p);
      int t[4];
      case (m)
         0: t = '{0, 0, 0, 10 + w};
         1: t = '{5, 20 + w, 10, 10};
         2: t = '{8, 30 + w, 15, 15};
         default: t = '{10, 40 + 2 * w, 20, 20};
      endcase
      return t[p];
   endfunction

   // {phase, valve_in, valve_out, motor, busy}
   function automatic logic [6:0] lights_of(input int p);
      case (p)
         0: return 7'b001_1_0_0_1;
         1: return 7'b001_0_0_1_1;
         2: return 7'b010_1_0_1_1;
         default: return 7'b100_0_1_1_1;
      endcase
   endfunction

   // Terminal state: count buzz samples, show start is ignored, then ack.
   task automatic finish_term(input bit is_err);
      int nb;
      nb = 0;
      for (int i = 0; i < 2 * TICK + 3; i++) begin
         if (buzz) nb++;
         if (i == 3) start = 1'b1;
         step();
         start = 1'b0;
      end
`ifdef BUZZ_EN
      chk("buzz_len", nb, 2 * TICK);
`else
      chk("buzz_len", nb, 0);
`endif
      chk("term_hold", is_err ? err : done, 1);
      ack_pos = 1'b1;
      step();
      ack_pos = 1'b0;
      chk("idle_flags", {busy, done, err, paused, phase}, 0);
      chk("idle_remain", remain_s, 0);
   endtask

   task automatic run_prog(input int m, input int w, input int bal,
                           input bit e_err, input int e_bal);
      int d;
      mode   = 2'(m);
      weight = 5'(w);
      bal_in = 12'(bal);
      start  = 1'b1;
      step();
      start  = 1'b0;
      chk("check_busy", busy, 1);
      step();
      if (e_err) begin
         chk("err", err, 1);
         chk("err_busy", busy, 0);
         chk("err_bal", bal_out, e_bal);
         finish_term(1'b1);
      end else begin
         chk("bal_out", bal_out, e_bal);
         for (int p = 0; p < 4; p++) begin
            d = dur(m, w, p);
            for (int k = 0; k <= d * TICK; k++) begin
               chk("remain", remain_s, d - k / TICK);
               chk("lights", w_lights, lights_of(p));
               step();
            end
         end
         chk("done", done, 1);
         chk("done_busy", busy, 0);
         chk("done_remain", remain_s, 0);
         finish_term(1'b0);
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      chk("reset_outs", w_all, 0);
      step();
      rst = 1'b1;
      step();
      chk("post_reset_outs", w_all, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, e_bal, m, w, bal;
      bit found, e_err;

      tbl[0]  = '{2, 11,    50, 1,  0};
      tbl[1]  = '{1,  3,    20, 0, 15};
      tbl[2]  = '{3,  0,    11, 1, 15};
      tbl[3]  = '{3,  0,    -5, 1, 15};
      tbl[4]  = '{3,  0,    12, 0,  0};
      tbl[5]  = '{0,  4,     3, 0,  1};
      tbl[6]  = '{1,  6,   100, 1,  1};
      tbl[7]  = '{1,  5,     5, 0,  0};
      tbl[8]  = '{2, 10,     8, 0,  0};
      tbl[9]  = '{0, 21,   100, 1,  0};
      tbl[10] = '{3, 20,    12, 0,  0};
      tbl[11] = '{0, 20, -2048, 1,  0};

      rst = 1'b0; start = 1'b0; pause_pos = 1'b0; ack_pos = 1'b0;
      lid_open = 1'b0; mode = 2'd0; weight = 5'd0; bal_in = 12'sd0;
      repeat (3) step();
      chk("reset_outs", w_all, 0);
      rst = 1'b1;
      step();
      pause_pos = 1'b1; ack_pos = 1'b1;
      step();
      pause_pos = 1'b0; ack_pos = 1'b0;
      chk("idle_ignores", w_all, 0);

      // ---- fixed vectors ----
      for (int i = 0; i < 12; i++)
         run_prog(tbl[i].m, tbl[i].w, tbl[i].bal, tbl[i].e_err, tbl[i].e_bal);

      // ---- lid interlock and pause in WASH, then reset in RINSE ----
      do_reset();
      mode = 2'd1; weight = 5'd3; bal_in = 12'sd20;
      start = 1'b1; step(); start = 1'b0; step();
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         if (phase == 3'b001 && motor && remain_s == 8'd7) found = 1'b1;
         else step();
      end
      chk("reach_wash7", found, 1);
      lid_open = 1'b1;
      step();
      chk("lid_paused", paused, 1);
      chk("lid_lights", w_lights, 7'b000_0_0_0_1);
      chk("lid_remain", remain_s, 7);
      repeat (5) step();
      chk("lid_frozen", remain_s, 7);
      pause_pos = 1'b1; step(); pause_pos = 1'b0;
      chk("lid_blocks_resume", paused, 1);
      lid_open = 1'b0;
      step();
      chk("no_pulse_no_resume", paused, 1);
      pause_pos = 1'b1; step(); pause_pos = 1'b0;
      chk("resumed", w_lights, lights_of(1));
      chk("resume_remain", remain_s, 7);
      n = 0;
      while (remain_s != 8'd0 && n < 100) begin
         step();
         n++;
      end
      chk("resume_ticks", n, 7 * TICK);
      step();
      chk("into_rinse", w_lights, lights_of(2));
      chk("rinse_remain", remain_s, 10);
      repeat (3) step();
      do_reset();

      // ---- pause coinciding with end of FILL: WASH entered paused ----
      mode = 2'd1; weight = 5'd0; bal_in = 12'sd10;
      start = 1'b1; step(); start = 1'b0; step();
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (valve_in && !motor && remain_s == 8'd0) found = 1'b1;
         else step();
      end
      chk("reach_fill_end", found, 1);
      pause_pos = 1'b1; step(); pause_pos = 1'b0;
      chk("edge_paused", paused, 1);
      chk("edge_remain", remain_s, 20);
      repeat (4) step();
      pause_pos = 1'b1; step(); pause_pos = 1'b0;
      chk("edge_resume", w_lights, lights_of(1));
      chk("edge_resume_remain", remain_s, 20);
      step();
      do_reset();

      // ---- random programs against the model ----
      e_bal = 0;
      for (int r = 0; r < 10; r++) begin
         m     = int'($urandom_range(0, 3));
         w     = int'($urandom_range(0, limit_of(m) + 3));
         bal   = int'($urandom_range(0, 40)) - 10;
         e_err = (w > limit_of(m)) || (bal < price_of(m));
         if (!e_err) e_bal = bal - price_of(m);
         run_prog(m, w, bal, e_err, e_bal);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wash_seq.md
Name: wash_seq

Overview:
- Wash-cycle scheduler that follows the pre-wash input stage.
- On a start pulse it does the following:
  - latches the mode, weight and balance;
  - checks the weight limit and the cost;
  - deducts the cost;
  - sequences the FILL, WASH, RINSE and SPIN phases with a seconds countdown.
- It drives the water valves, the motor, the phase lights and the remaining-time value shown on the digit display.
- It supports pause and resume, and a lid-open interlock.

Parameters:
- TICK_CYC, 100000000: clock cycles per second tick (100 MHz clk).
- PRICE0, 2: cost of mode 0 (spin only).
- PRICE1, 5: cost of mode 1 (small).
- PRICE2, 8: cost of mode 2 (medium).
- PRICE3, 12: cost of mode 3 (large).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; request to begin a program.
- mode  in  2  program select: 0 spin, 1 small, 2 medium, 3 large.
- weight  in  5  load weight in kg, 0..31.
- bal_in  in  12 signed  current balance.
- pause_pos  in  1  one-cycle debounced button pulse; toggles pause.
- ack_pos  in  1  one-cycle pulse; acknowledges DONE or ERR.
- lid_open  in  1  level; 1 means the lid is open.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- phase  out  3  one-hot phase light: 001 FILL/WASH, 010 RINSE, 100 SPIN, 000 otherwise.
- remain_s  out  8  seconds left in the current phase.
- bal_out  out  12 signed  balance after deduction.
- valve_in  out  1  high in FILL and RINSE.
- valve_out  out  1  high in SPIN.
- motor  out  1  high in WASH, RINSE and SPIN.
- done  out  1  high while in DONE.
- err  out  1  high while in ERR.
- paused  out  1  high while in PAUSE.
- buzz  out  1  see Optional Feature.

Behaviour:
- Reset values: state IDLE; every output 0; bal_out 0; prescaler 0.
- States: IDLE, CHECK, FILL, WASH, RINSE, SPIN, PAUSE, DONE, ERR.
- IDLE:
  - start=1 latches mode, weight and bal_in, then goes to CHECK next cycle.
  - All other inputs are ignored.
- CHECK (exactly 1 cycle):
  - Weight limits: mode1 ≤5, mode2 ≤10, mode0 and mode3 ≤20.
  - cost = PRICEm.
  - Go to ERR if weight exceeds the limit, or bal < cost (signed compare; a negative balance always fails). bal_out is unchanged.
  - Otherwise bal_out <= bal - cost, and go to the first phase.
- Phase durations in seconds (w = latched weight):

  | Mode | FILL | WASH | RINSE | SPIN |
  |---|---|---|---|---|
  | 0 | 0 | 0 | 0 | 10+w |
  | 1 | 5 | 20+w | 10 | 10 |
  | 2 | 8 | 30+w | 15 | 15 |
  | 3 | 10 | 40+2w | 20 | 20 |

  - The maximum duration is 80 and fits in 8 bits.
- Phase entry:
  - remain_s <= duration, and the prescaler is cleared.
  - A phase with duration 0 is skipped: the state advances on the next cycle, with remain_s 0.
- Counting:
  - The prescaler counts 0..TICK_CYC-1. At wrap, remain_s decrements.
  - When the decrement takes remain_s from 1 to 0, the next clock enters the next phase.
  - After SPIN the next state is DONE.
- Pause:
  - pause_pos in a phase state enters PAUSE and saves the return phase.
  - Prescaler and remain_s are frozen; valve_in, valve_out and motor are forced to 0.
  - lid_open=1 in any phase state forces PAUSE in the next cycle.
  - From PAUSE, pause_pos resumes only if lid_open=0; otherwise it is ignored.
  - On resume the saved phase continues from the frozen prescaler and remain_s values.
- Simultaneous events: if pause_pos arrives in the same cycle as a phase-ending tick, the transition is taken first, and the new phase is entered already paused (save that phase, remain_s = its duration).
- DONE and ERR: hold until ack_pos, then go to IDLE; remain_s is cleared. start is ignored in these states.
- Reset mid-operation: all outputs go to reset values immediately; any deducted balance is not restored.

Optional Feature:
- Macro BUZZ_EN.
- Defined: buzz goes high for 2 ticks (2*TICK_CYC cycles) on entry to DONE or ERR. A later ack_pos does not cut it short. An asynchronous reset clears it.
- Not defined: buzz is tied to 0 and no extra counter is built.

Test Plan:
All scenarios use TICK_CYC=4.
1. Reset, then start with mode1, w=3, bal=20 → bal_out=15; FILL 5 ticks, WASH 23, RINSE 10, SPIN 10 → done=1; ack_pos → IDLE.
2. Start with mode2, w=11, bal=50 → err=1, bal_out=0, busy=0; ack_pos → IDLE.
3. Start with mode3, w=0, bal=11, then bal=-5 → err both times; then bal=12 → bal_out=0 and the program runs.
4. Mode0, w=4 → FILL, WASH and RINSE are skipped in 1 cycle each; SPIN with remain_s=14, valve_out=1, motor=1.
5. In WASH with remain_s=7:
   - lid_open=1 → PAUSE, motor=0, remain_s stays 7;
   - pause_pos with the lid still open → stays in PAUSE;
   - lid closed, then pause_pos → WASH resumes, and reaches 0 after 7 ticks.
6. Assert rst in RINSE → all outputs 0 and IDLE; with BUZZ_EN, buzz is high for exactly 8 cycles after DONE entry.
